// File: rtl/seq_detect_arbiter_pkg.sv
// Shared types and constants for the round-robin 101/001 pattern-detector slice.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] PAT_101 = 3'b101;
  localparam logic [2:0] PAT_001 = 3'b001;

endpackage

// File: rtl/seq_detect_arbiter_if.sv
// Requester-side bundle: level requests, parallel words, grant and the per-frame results.
interface seq_detect_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*FRAME_LEN-1:0] req_data;
  logic [NUM_REQ-1:0]           gnt;
  logic                         busy;
  logic                         done;
  logic [CNT_W-1:0]             cnt_101;
  logic [CNT_W-1:0]             cnt_001;

  modport master (
    output req, req_data,
    input  gnt, busy, done, cnt_101, cnt_001
  );

  modport slave (
    input  req, req_data,
    output gnt, busy, done, cnt_101, cnt_001
  );
endinterface

// File: rtl/seq_detect_arbiter_core.sv
// Serial 101/001 detector: 3-bit history with a fill count so no match is reported
// before three bits of the current frame have arrived. Hits are registered.
module seq_detect_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic valid,
  input  logic x,
  output logic hit101,
  output logic hit001
);

  logic [2:0] hist;
  logic [1:0] fill;
  logic [2:0] hist_next;
  logic       full_next;

  always_comb begin
    hist_next = {hist[1:0], x};
    full_next = (fill >= 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      hist   <= '0;
      fill   <= '0;
      hit101 <= 1'b0;
      hit001 <= 1'b0;
    end else if (valid) begin
      hist   <= hist_next;
      fill   <= (fill == 2'd3) ? 2'd3 : fill + 2'd1;
      hit101 <= full_next && (hist_next == PAT_101);
      hit001 <= full_next && (hist_next == PAT_001);
    end else begin
      hit101 <= 1'b0;
      hit001 <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin front end that serialises one requester's word at a time into the
// shared detector core and reports saturating 101/001 hit counts with a done pulse.
module seq_detect_arbiter
  import seq_det_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input logic                clk,
  input logic                reset,
  seq_detect_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BIT_W = $clog2(FRAME_LEN);

  state_t               state;
  state_t               state_next;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     ptr_after;
  logic                 found;
  logic                 grant;
  logic                 last_bit;
  logic [FRAME_LEN-1:0] shreg;
  logic [BIT_W-1:0]     bitcnt;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [CNT_W-1:0]     cnt101_q;
  logic [CNT_W-1:0]     cnt001_q;
  logic                 hit101;
  logic                 hit001;

  // First set request at or above ptr, wrapping; ptr itself has top priority.
  always_comb begin : arb_search
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ptr_after = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
    grant     = (state == IDLE) && found;
    last_bit  = (bitcnt == BIT_W'(FRAME_LEN - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      shreg  <= '0;
      bitcnt <= '0;
      gnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            shreg  <= bus.req_data[int'(winner)*FRAME_LEN +: FRAME_LEN];
            gnt_q  <= NUM_REQ'(1) << winner;
            bitcnt <= '0;
            ptr    <= ptr_after;
          end
        end
        SHIFT: begin
          shreg  <= shreg << 1;
          bitcnt <= bitcnt + BIT_W'(1);
        end
        DONE:    gnt_q <= '0;
        default: ;
      endcase
    end
  end

  // Counters keep the last frame's result until the next grant edge clears them.
  always_ff @(posedge clk) begin
    if (reset || grant) begin
      cnt101_q <= '0;
      cnt001_q <= '0;
    end else begin
      if (hit101 && (cnt101_q != {CNT_W{1'b1}})) cnt101_q <= cnt101_q + CNT_W'(1);
      if (hit001 && (cnt001_q != {CNT_W{1'b1}})) cnt001_q <= cnt001_q + CNT_W'(1);
    end
  end

  seq_detect_core u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (grant),
    .valid  (state == SHIFT),
    .x      (shreg[FRAME_LEN-1]),
    .hit101 (hit101),
    .hit001 (hit001)
  );

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign bus.cnt_101 = cnt101_q;
  assign bus.cnt_001 = cnt001_q;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Scoreboard bench: the driver predicts winner and hit counts from the frame word,
// monitors pop and compare whenever a DUT raises done.
module tb_seq_detect_arbiter;

  localparam int NR  = 4;
  localparam int FL  = 8;
  localparam int CW  = 4;
  localparam int FL2 = 16;
  localparam int CW2 = 2;

  typedef struct {
    logic [NR-1:0] gnt;
    int            c101;
    int            c001;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_detect_arbiter_if #(.NUM_REQ(NR), .FRAME_LEN(FL),  .CNT_W(CW))  bus  ();
  seq_detect_arbiter_if #(.NUM_REQ(NR), .FRAME_LEN(FL2), .CNT_W(CW2)) bus2 ();

  seq_detect_arbiter #(.NUM_REQ(NR), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  seq_detect_arbiter #(.NUM_REQ(NR), .FRAME_LEN(FL2), .CNT_W(CW2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  exp_t sb[$];
  exp_t sb2[$];
  int   errors = 0;
  int   checks = 0;
  int   model_ptr = 0;
  int   model_ptr2 = 0;
  int   busy_run = 0;
  bit   after_done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Hits are the 3-bit windows read MSB first, oldest bit leftmost, capped at 2^cw-1.
  function automatic int count_pat(input logic [15:0] w, input int len,
                                   input logic [2:0] pat, input int cw);
    int n;
    n = 0;
    for (int i = len - 1; i >= 2; i--)
      if ({w[i], w[i-1], w[i-2]} == pat) n++;
    if (n > (1 << cw) - 1) n = (1 << cw) - 1;
    return n;
  endfunction

  function automatic int pick(input logic [7:0] r, input int n, input int p);
    for (int k = 0; k < n; k++)
      if (r[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  task automatic waitIdle();
    int n;
    n = 0;
    while (bus.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(bus.busy), 0);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_gnt"},  int'(bus.gnt),     0);
    check({tag, "_busy"}, int'(bus.busy),    0);
    check({tag, "_done"}, int'(bus.done),    0);
    check({tag, "_c101"}, int'(bus.cnt_101), 0);
    check({tag, "_c001"}, int'(bus.cnt_001), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset");
    check("reset2_gnt",  int'(bus2.gnt),  0);
    check("reset2_busy", int'(bus2.busy), 0);
    model_ptr  = 0;
    model_ptr2 = 0;
    reset = 1'b0;
  endtask

  // Called at a negedge while the DUT is idle; abort_cycle>0 resets mid-frame.
  task automatic applyStimulus(input logic [NR-1:0] r, input logic [NR*FL-1:0] data,
                               input bit hold, input int abort_cycle);
    int            win;
    exp_t          e;
    logic [FL-1:0] w;
    bus.req      = r;
    bus.req_data = data;
    win = pick(8'(r), NR, model_ptr);
    if (win >= 0) begin
      w      = data[win*FL +: FL];
      e.gnt  = NR'(1) << win;
      e.c101 = count_pat(16'(w), FL, 3'b101, CW);
      e.c001 = count_pat(16'(w), FL, 3'b001, CW);
      sb.push_back(e);
      model_ptr = (win + 1) % NR;
    end
    @(negedge clk);
    bus.req_data = $urandom;
    if (!hold) bus.req = '0;
    if (abort_cycle > 0 && win >= 0) begin
      repeat (abort_cycle - 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort");
      sb.delete();
      model_ptr = 0;
      reset = 1'b0;
    end else begin
      waitIdle();
    end
  endtask

  task automatic runDut2(input logic [NR-1:0] r, input logic [NR*FL2-1:0] data);
    int             win;
    int             n;
    exp_t           e;
    logic [FL2-1:0] w;
    bus2.req      = r;
    bus2.req_data = data;
    win = pick(8'(r), NR, model_ptr2);
    if (win >= 0) begin
      w      = data[win*FL2 +: FL2];
      e.gnt  = NR'(1) << win;
      e.c101 = count_pat(w, FL2, 3'b101, CW2);
      e.c001 = count_pat(w, FL2, 3'b001, CW2);
      sb2.push_back(e);
      model_ptr2 = (win + 1) % NR;
    end
    @(negedge clk);
    bus2.req      = '0;
    bus2.req_data = {$urandom, $urandom};
    n = 0;
    while (bus2.busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle2_timeout", int'(bus2.busy), 0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      busy_run   = 0;
      after_done = 1'b0;
    end else begin
      if (bus.busy) begin
        busy_run++;
        check("busy_has_expect", int'(sb.size() > 0), 1);
        if (sb.size() > 0) check("gnt_hold", int'(bus.gnt), int'(sb[0].gnt));
      end
      if (bus.done) begin
        exp_t e;
        check("done_latency", busy_run, FL + 2);
        check("done_has_expect", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("cnt_101", int'(bus.cnt_101), e.c101);
          check("cnt_001", int'(bus.cnt_001), e.c001);
          check("gnt_at_done", int'(bus.gnt), int'(e.gnt));
        end
        after_done = 1'b1;
      end else if (after_done) begin
        check("gnt_after_done", int'(bus.gnt), 0);
        after_done = 1'b0;
      end
      if (!bus.busy) busy_run = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset && bus2.done) begin
      exp_t e;
      check("done2_has_expect", int'(sb2.size() > 0), 1);
      if (sb2.size() > 0) begin
        e = sb2.pop_front();
        check("cnt2_101", int'(bus2.cnt_101), e.c101);
        check("cnt2_001", int'(bus2.cnt_001), e.c001);
        check("gnt2_at_done", int'(bus2.gnt), int'(e.gnt));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [NR-1:0]    r;
    logic [NR*FL-1:0] d;
    bus.req       = '0;
    bus.req_data  = '0;
    bus2.req      = '0;
    bus2.req_data = '0;
    @(negedge clk);
    doReset();

    applyStimulus(4'b0001, {24'h0, 8'b10101001}, 1'b0, 0);
    applyStimulus(4'b0100, {8'h0, 8'b00100100, 16'h0}, 1'b0, 0);
    applyStimulus(4'b0100, 32'h0, 1'b0, 0);
    applyStimulus(4'b0000, 32'hFFFF_FFFF, 1'b0, 0);

    doReset();
    for (int i = 0; i < 5; i++)
      applyStimulus(4'b1011, $urandom, 1'b1, 0);
    bus.req = '0;

    doReset();
    applyStimulus(4'b0001, {24'h0, 8'b10101010}, 1'b0, 4);
    applyStimulus(4'b0101, {8'h0, 8'b00100001, 8'h0, 8'b01011010}, 1'b0, 0);

    applyStimulus(4'b0010, {16'h0, 8'b00000010, 8'h0}, 1'b0, 0);
    applyStimulus(4'b0010, {16'h0, 8'b10000000, 8'h0}, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      r = 4'($urandom_range(0, 15));
      d = $urandom;
      applyStimulus(r, d, 1'($urandom_range(0, 1)), 0);
    end
    bus.req = '0;

    runDut2(4'b0001, {48'h0, 16'hAAAA});
    runDut2(4'b0010, {32'h0, 16'h2492, 16'h0});
    for (int i = 0; i < 3; i++)
      runDut2(4'($urandom_range(1, 15)), {$urandom, $urandom});

    repeat (4) @(negedge clk);
    check("sb_drained",  sb.size(),  0);
    check("sb2_drained", sb2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
